// File: rtl/multicycle_cpu.sv
// Multi-cycle CPU: register file, registered ALU, data memory and an IDLE/EXEC/MEM/WB
// control FSM fed by a valid/ready instruction port.
module multicycle_cpu #(
   parameter int unsigned DATA_WIDTH    = 8,
   parameter int unsigned ADDR_BITS     = 5,
   parameter int unsigned MEM_ADDR_BITS = 5,
   parameter int unsigned INSTR_WIDTH   = 20
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [INSTR_WIDTH-1:0] instr,
   input  logic                   instr_valid,
   output logic                   instr_ready,
   output logic                   done,
   output logic [DATA_WIDTH-1:0]  result,
   output logic                   zero,
   output logic                   carry,
   output logic                   illegal,
   input  logic [ADDR_BITS-1:0]   dbg_addr,
   output logic [DATA_WIDTH-1:0]  dbg_data
);

   localparam int unsigned IMM_W = INSTR_WIDTH - 4 - 2 * ADDR_BITS;
   localparam int unsigned SH_W  = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam int unsigned NREG  = 2 ** ADDR_BITS;
   localparam int unsigned NMEM  = 2 ** MEM_ADDR_BITS;

   typedef enum logic [1:0] {StIdle, StExec, StMem, StWb} state_e;

   typedef enum logic [3:0] {
      OpNop  = 4'd0,  OpAdd = 4'd1, OpSub = 4'd2, OpAnd  = 4'd3,
      OpOr   = 4'd4,  OpXor = 4'd5, OpShl = 4'd6, OpShr  = 4'd7,
      OpAddi = 4'd8,  OpLd  = 4'd9, OpSt  = 4'd10, OpMovi = 4'd11
   } op_e;

   state_e state_q, state_d;

   logic [INSTR_WIDTH-1:0]           instr_q;
   logic [NREG-1:0][DATA_WIDTH-1:0]  regs;
   logic [NMEM-1:0][DATA_WIDTH-1:0]  mem;
   logic [DATA_WIDTH-1:0]            alu_q;
   logic [MEM_ADDR_BITS-1:0]         ea_q;
   logic [DATA_WIDTH-1:0]            result_q;
   logic                             zero_q, carry_q, done_q, illegal_q;

   // Instruction field decode from the latched word
   logic [3:0]            op;
   logic [ADDR_BITS-1:0]  rd, rs1, rs2;
   logic [IMM_W-1:0]      f;
   logic [DATA_WIDTH-1:0] imm;

   assign op  = instr_q[INSTR_WIDTH-1 -: 4];
   assign rd  = instr_q[INSTR_WIDTH-5 -: ADDR_BITS];
   assign rs1 = instr_q[INSTR_WIDTH-5-ADDR_BITS -: ADDR_BITS];
   assign f   = instr_q[IMM_W-1:0];
   assign rs2 = f[ADDR_BITS-1:0];
   assign imm = DATA_WIDTH'($signed(f));

   logic [DATA_WIDTH-1:0]    op_a, op_b, alu_res;
   logic                     alu_c;
   logic [MEM_ADDR_BITS-1:0] ea;
   logic                     flag_upd, reg_wr, is_illegal;

   always_comb begin
      op_a    = regs[rs1];
      op_b    = regs[rs2];
      alu_res = '0;
      alu_c   = 1'b0;
      case (op)
         OpAdd:   {alu_c, alu_res} = {1'b0, op_a} + {1'b0, op_b};
         // Bit DATA_WIDTH of the extended difference is the unsigned borrow
         OpSub:   {alu_c, alu_res} = {1'b0, op_a} - {1'b0, op_b};
         OpAnd:   alu_res = op_a & op_b;
         OpOr:    alu_res = op_a | op_b;
         OpXor:   alu_res = op_a ^ op_b;
         OpShl:   alu_res = op_a << op_b[SH_W-1:0];
         OpShr:   alu_res = op_a >> op_b[SH_W-1:0];
         OpAddi:  {alu_c, alu_res} = {1'b0, op_a} + {1'b0, imm};
         OpMovi:  alu_res = imm;
         default: ;
      endcase
   end

   assign ea         = MEM_ADDR_BITS'(op_a + imm);
   assign flag_upd   = (op >= 4'd1) && (op <= 4'd8);
   assign reg_wr     = (op >= 4'd1) && (op <= 4'd11) && (op != OpSt);
   assign is_illegal = (op >= 4'd12);

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      instr_ready = 1'b0;
      unique case (state_q)
         StIdle: begin
            instr_ready = 1'b1;
            if (instr_valid) state_d = StExec;
         end
         StExec:  state_d = (op == OpLd || op == OpSt) ? StMem : StWb;
         StMem:   state_d = (op == OpSt) ? StIdle : StWb;
         StWb:    state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         instr_q   <= '0;
         regs      <= '0;
         mem       <= '0;
         alu_q     <= '0;
         ea_q      <= '0;
         result_q  <= '0;
         zero_q    <= 1'b0;
         carry_q   <= 1'b0;
         done_q    <= 1'b0;
         illegal_q <= 1'b0;
      end else begin
         done_q    <= 1'b0;
         illegal_q <= 1'b0;
         case (state_q)
            StIdle: if (instr_valid) instr_q <= instr;
            StExec: begin
               alu_q <= alu_res;
               ea_q  <= ea;
               if (flag_upd) begin
                  zero_q  <= (alu_res == '0);
                  carry_q <= alu_c;
               end
            end
            StMem: begin
               if (op == OpSt) begin
                  mem[ea_q] <= regs[rd];
                  result_q  <= regs[rd];
                  done_q    <= 1'b1;
               end else begin
                  alu_q <= mem[ea_q];
               end
            end
            StWb: begin
               if (reg_wr) begin
                  regs[rd] <= alu_q;
                  result_q <= alu_q;
               end
               done_q    <= 1'b1;
               illegal_q <= is_illegal;
            end
            default: ;
         endcase
      end
   end

   assign done     = done_q;
   assign illegal  = illegal_q;
   assign result   = result_q;
   assign zero     = zero_q;
   assign carry    = carry_q;
   assign dbg_data = regs[dbg_addr];

endmodule

// File: tb/tb_multicycle_cpu.sv
// Scoreboard bench for multicycle_cpu: driver runs an arithmetic reference model and queues
// expected retirements; a negedge monitor pops and compares on every done pulse.
module tb_multicycle_cpu;

   localparam int DW = 8;
   localparam int AB = 5;
   localparam int MB = 5;
   localparam int IW = 20;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic [IW-1:0] instr = '0;
   logic          instr_valid = 1'b0;
   logic          instr_ready;
   logic          done;
   logic [DW-1:0] result;
   logic          zero, carry, illegal;
   logic [AB-1:0] dbg_addr = '0;
   logic [DW-1:0] dbg_data;

   multicycle_cpu #(
      .DATA_WIDTH(DW), .ADDR_BITS(AB), .MEM_ADDR_BITS(MB), .INSTR_WIDTH(IW)
   ) dut (
      .clk(clk), .rst(rst), .instr(instr), .instr_valid(instr_valid),
      .instr_ready(instr_ready), .done(done), .result(result), .zero(zero),
      .carry(carry), .illegal(illegal), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
   );

   always #5 clk = ~clk;

   typedef struct {
      int res;
      int z;
      int c;
      int ill;
      int lat;
      int acc;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   rm[32];
   int   mm[32];
   int   m_res, m_z, m_c;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Monitor: every done must match the oldest outstanding expectation
   always @(negedge clk) begin
      if (done) begin
         if (sb.size() == 0) begin
            chk("unexpected_done", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("result",  32'(result),  32'(e.res));
            chk("zero",    32'(zero),    32'(e.z));
            chk("carry",   32'(carry),   32'(e.c));
            chk("illegal", 32'(illegal), 32'(e.ill));
            chk("latency", 32'(cyc - e.acc), 32'(e.lat));
         end
      end else if (illegal) begin
         chk("illegal_without_done", 32'd1, 32'd0);
      end
   end

   function automatic logic [IW-1:0] enc(input int op, input int rd, input int rs1, input int f);
      logic [3:0] o;
      logic [4:0] d, s;
      logic [5:0] ff;
      o = 4'(op); d = 5'(rd); s = 5'(rs1); ff = 6'(f);
      return {o, d, s, ff};
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 32; i++) begin
         rm[i] = 0;
         mm[i] = 0;
      end
      m_res = 0; m_z = 0; m_c = 0;
   endtask

   // Reference behaviour straight from the instruction semantics, modulo 256
   task automatic model(input int op, input int rd, input int rs1, input int f, input int acc);
      int a, b, imm, ea, r, lat, ill;
      exp_t e;
      a   = rm[rs1];
      b   = rm[f % 32];
      imm = (f >= 32) ? f - 64 : f;
      ea  = (((a + imm) % 32) + 32) % 32;
      lat = 2; ill = 0; r = 0;
      case (op)
         1:  begin r = (a + b) % 256; m_c = (a + b > 255) ? 1 : 0; end
         2:  begin r = (a - b + 256) % 256; m_c = (a < b) ? 1 : 0; end
         3:  begin r = a & b; m_c = 0; end
         4:  begin r = a | b; m_c = 0; end
         5:  begin r = a ^ b; m_c = 0; end
         6:  begin r = (a << (b % 8)) % 256; m_c = 0; end
         7:  begin r = a >> (b % 8); m_c = 0; end
         8:  begin r = (a + imm + 256) % 256; m_c = (a + ((imm + 256) % 256) > 255) ? 1 : 0; end
         9:  begin r = mm[ea]; lat = 3; end
         10: mm[ea] = rm[rd];
         11: r = (imm + 256) % 256;
         default: if (op >= 12) ill = 1;
      endcase
      if (op >= 1 && op <= 8) m_z = (r == 0) ? 1 : 0;
      if (op >= 1 && op <= 11 && op != 10) begin
         rm[rd] = r;
         m_res  = r;
      end
      if (op == 10) m_res = rm[rd];
      e.res = m_res; e.z = m_z; e.c = m_c; e.ill = ill; e.lat = lat; e.acc = acc;
      sb.push_back(e);
   endtask

   // Called at a negedge; leaves at the negedge just after the accepting edge
   task automatic issue(input int op, input int rd, input int rs1, input int f, input bit hold);
      int n;
      instr = enc(op, rd, rs1, f);
      instr_valid = 1'b1;
      n = 0;
      while (!instr_ready && n < 10) begin
         @(negedge clk);
         n++;
      end
      chk("ready_timeout", 32'(instr_ready), 32'd1);
      model(op, rd, rs1, f, cyc + 1);
      @(negedge clk);
      if (!hold) instr_valid = 1'b0;
   endtask

   task automatic drain();
      int n;
      instr_valid = 1'b0;
      n = 0;
      while (sb.size() != 0 && n < 20) begin
         @(negedge clk);
         n++;
      end
      @(negedge clk);
      chk("drain_outstanding", 32'(sb.size()), 32'd0);
   endtask

   task automatic dbg_read(input int idx, output logic [DW-1:0] v);
      dbg_addr = 5'(idx);
      #1;
      v = dbg_data;
   endtask

   task automatic check_regs();
      logic [DW-1:0] v;
      int bad;
      bad = 0;
      for (int i = 0; i < 32; i++) begin
         dbg_read(i, v);
         if (32'(v) !== 32'(rm[i])) begin
            bad++;
            $display("FAIL dbg_reg%0d got 0x%0h expected 0x%0h", i, v, rm[i]);
         end
      end
      checks++;
      if (bad != 0) errors++;
   endtask

   initial begin
      logic [DW-1:0] v;
      model_reset();
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("reset_ready",   32'(instr_ready), 32'd1);
      chk("reset_done",    32'(done),        32'd0);
      chk("reset_result",  32'(result),      32'd0);
      chk("reset_flags",   32'({zero, carry, illegal}), 32'd0);
      check_regs();

      // Put a value in memory, then abort a load of it during its MEM cycle
      issue(11, 1, 0, 5, 1'b0);
      issue(10, 1, 0, 1, 1'b0);
      drain();
      instr = enc(9, 6, 0, 1);
      instr_valid = 1'b1;
      @(negedge clk);
      instr_valid = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      model_reset();
      @(negedge clk);
      chk("postreset_ready", 32'(instr_ready), 32'd1);
      chk("postreset_result", 32'(result), 32'd0);
      check_regs();
      // Memory was cleared too: a load from the stored address must see 0
      issue(9, 6, 0, 1, 1'b0);
      drain();

      // Directed sequence, instr_valid held high throughout
      issue(11, 1, 0, 5, 1'b1);
      issue(11, 2, 0, 61, 1'b1);       // -3
      issue(1, 3, 1, 2, 1'b1);
      issue(2, 4, 1, 1, 1'b1);
      issue(2, 5, 1, 2, 1'b1);
      issue(10, 1, 2, 4, 1'b1);
      issue(9, 6, 0, 1, 1'b1);
      issue(11, 8, 0, 9, 1'b1);
      issue(6, 7, 1, 8, 1'b1);
      issue(11, 9, 0, 2, 1'b1);
      issue(7, 10, 1, 9, 1'b1);
      issue(5, 1, 1, 1, 1'b1);
      issue(13, 3, 1, 2, 1'b1);
      drain();
      dbg_read(2, v);  chk("r2_movi_neg", 32'(v), 32'h0fd);
      dbg_read(3, v);  chk("r3_add",      32'(v), 32'h002);
      dbg_read(4, v);  chk("r4_sub_self", 32'(v), 32'h000);
      dbg_read(5, v);  chk("r5_sub_brw",  32'(v), 32'h008);
      dbg_read(6, v);  chk("r6_ld",       32'(v), 32'h005);
      dbg_read(7, v);  chk("r7_shl",      32'(v), 32'h00a);
      dbg_read(10, v); chk("r10_shr",     32'(v), 32'h001);
      dbg_read(1, v);  chk("r1_xor",      32'(v), 32'h000);
      chk("zero_after_illegal", 32'(zero), 32'd1);
      check_regs();

      // Random traffic over a small register window to force dependencies
      for (int i = 0; i < 300; i++) begin
         int gap;
         gap = $urandom_range(0, 3);
         if (gap == 3) begin
            instr_valid = 1'b0;
            repeat ($urandom_range(1, 2)) @(negedge clk);
         end
         issue($urandom_range(0, 15), $urandom_range(0, 7), $urandom_range(0, 7),
               $urandom_range(0, 63), ($urandom_range(0, 1) == 1));
      end
      drain();
      check_regs();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog_timeout got 1 expected 0");
      $fatal(1, "watchdog");
   end

endmodule
